stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer. Successor to the fixed 8-bit 2:1 mux.
- Adds a registered output stage, valid/ready handshaking on every channel, and a selectable mode: external select or round-robin arbitration.
- Sits between multiple producers (register file ports, ALU result buses) and a single consumer. Gives that consumer one registered, back-pressurable stream tagged with its source channel.

Parameters:
- WIDTH, 8, data bits per channel.
- N, 2, number of input channels (>=2).
- MODE, 0, 0 = external select, 1 = round-robin arbitration.
- SELW, $clog2(N), width of sel and out_chan (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- sel  in  SELW  channel select. Used in MODE 0 only; ignored in MODE 1.
- in_valid  in  N  per-channel data valid.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  N  per-channel accept; at most one bit set.
- out_valid  out  1  output register holds data.
- out_data  out  WIDTH  registered output data.
- out_chan  out  SELW  source channel of out_data.
- out_ready  in  1  consumer accepts out_data.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, rr_ptr=N-1, so channel 0 has first priority.

Grant (combinational):
- MODE 0: grant=sel, grant_vld = (sel<N) && in_valid[sel]. If sel>=N, no grant and in_ready stays all zero.
- MODE 1: grant = first i with in_valid[i]=1, searching rr_ptr+1, rr_ptr+2, … modulo N. grant_vld = |in_valid.
- in_ready may depend combinationally on in_valid (MODE 1) and on sel (MODE 0). No path from out_data to in_ready.

Handshake:
- space = !out_valid || out_ready.
- in_ready[i] = space && grant_vld && (i==grant). Never more than one hot.
- An input transfer occurs when in_valid[i] && in_ready[i].
- On transfer: out_data <= in_data[grant], out_chan <= grant, out_valid <= 1. In MODE 1, rr_ptr <= grant.
- If out_valid && out_ready and no input transfer: out_valid <= 0. out_data and out_chan hold their values.
- Simultaneous drain and load in one cycle: the new word replaces the old one, out_valid stays 1. This sustains full throughput of one word per cycle.
- Stall (out_valid && !out_ready): out_data and out_chan stay stable, in_ready is all zero, rr_ptr is unchanged.

Timing and rules:
- Latency: one cycle from an input transfer to out_valid.
- rr_ptr advances only on a transfer, never on idle cycles. No channel waits more than N-1 transfers while it holds in_valid high.
- A producer must not drop in_valid once asserted until it is accepted. The block does not check this.
- A sel change mid-stall is allowed; grant is re-evaluated every cycle.
- Reset mid-transfer discards the held word with no output handshake.
- Wrap-around: rr_ptr=N-1 searches from channel 0. For non-power-of-2 N, out-of-range indices are never granted.

Decomposition:
- Shared package stream_mux_pkg holds:
  - constants MODE_SELECT=0 and MODE_RR=1;
  - a function chan_slice(data, i, WIDTH) that extracts the channel field.
- One sub-module, rr_arbiter (N): inputs req[N] and ptr; outputs grant index and grant_vld. Purely combinational.
- The top level holds the rr_ptr register, the output register and the handshake logic. The MODE 0 path bypasses rr_arbiter through a generate block.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with in_valid=2'b11 -> out_valid=0, out_data=0, out_chan=0 immediately. in_ready=0 while in reset.
- MODE 0, N=2, WIDTH=8: sel=1, in_valid=2'b11, in_data={8'hB2,8'hA1}, out_ready=1 -> in_ready=2'b10. Next cycle out_data=8'hB2, out_chan=1, out_valid=1.
- Backpressure: out_valid=1 (out_data=8'h11), out_ready=0 for 3 cycles while channel 0 presents 8'h22 -> in_ready=0 and out_data=8'h11 throughout. out_ready=1 -> 8'h22 loads on the same edge the old word drains, out_valid stays 1.
- Round-robin fairness, MODE 1, N=4: all in_valid=1, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
- RR skip and wrap, N=3: rr_ptr=1, in_valid=3'b001 -> grant 0 (wrap past channel 2). Then in_valid=3'b011 -> grant 1.
- MODE 0 invalid select, N=3: sel=3 with in_valid=3'b111 -> in_ready=0, out_valid stays 0 for 5 cycles.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream_mux_rr block family.
package stream_mux_pkg;

  localparam int MODE_SELECT = 0;
  localparam int MODE_RR     = 1;

  // chan_slice works on a bus of up to BUS_W bits and a channel field of up to MAX_W bits.
  localparam int BUS_W = 1024;
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] chan_slice(input logic [BUS_W-1:0] data,
                                                  input int unsigned      i,
                                                  input int unsigned      width);
    logic [BUS_W-1:0] sh;
    logic [MAX_W-1:0] mask;
    sh   = data >> (i * width);
    mask = (MAX_W'(1) << width) - MAX_W'(1);
    return MAX_W'(sh) & mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N    = 2,
  parameter int PTRW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [PTRW-1:0] ptr,
  output logic [PTRW-1:0] grant,
  output logic            grant_vld
);

  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    // Search starts one past the last winner so it ends up at lowest priority.
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant = PTRW'(idx);
        found = 1'b1;
      end
    end
    grant_vld = |req;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with valid/ready handshake; external select or round-robin.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 2,
  parameter int MODE  = 0,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SELW-1:0]      sel,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  input  logic                 out_ready
);

  logic [SELW-1:0]  grant;
  logic             grant_vld;
  logic             space;
  logic             xfer;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_chan_q,  out_chan_d;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
      logic            unused_sel;

      assign unused_sel = ^sel;

      rr_arbiter #(.N(N), .PTRW(SELW)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_vld (grant_vld)
      );

      always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) rr_ptr_d = grant;
      end

      // Reset to N-1 so the first search begins at channel 0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= SELW'(N - 1);
        else        rr_ptr_q <= rr_ptr_d;
      end
    end else begin : g_sel
      always_comb begin
        grant     = sel;
        grant_vld = 1'b0;
        // Out-of-range selects match no channel and so never grant.
        for (int i = 0; i < N; i++) begin
          if (int'(sel) == i) grant_vld = in_valid[i];
        end
      end
    end
  endgenerate

  always_comb begin
    space = !out_valid_q || out_ready;
    xfer  = rst_n && space && grant_vld;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer && (int'(grant) == i);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = WIDTH'(chan_slice(BUS_W'(in_data), int'(grant), WIDTH));
      out_chan_d  = grant;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: four instances covering both modes and N=2/3/4.
module tb_stream_mux_rr;

  logic clk;
  logic rst_n;

  logic [1:0]  sel  [4];
  logic [3:0]  iv   [4];
  logic [31:0] id   [4];
  logic        ordy [4];

  logic [3:0]  ir [4];
  logic        ov [4];
  logic [7:0]  od [4];
  logic [1:0]  oc [4];

  logic [1:0] ir_a;  logic ov_a;  logic [7:0] od_a;  logic [0:0] oc_a;
  logic [3:0] ir_b;  logic ov_b;  logic [7:0] od_b;  logic [1:0] oc_b;
  logic [2:0] ir_c;  logic ov_c;  logic [7:0] od_c;  logic [1:0] oc_c;
  logic [2:0] ir_d;  logic ov_d;  logic [7:0] od_d;  logic [1:0] oc_d;

  stream_mux_rr #(.WIDTH(8), .N(2), .MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .sel(sel[0][0:0]), .in_valid(iv[0][1:0]),
    .in_data(id[0][15:0]), .in_ready(ir_a), .out_valid(ov_a), .out_data(od_a),
    .out_chan(oc_a), .out_ready(ordy[0]));

  stream_mux_rr #(.WIDTH(8), .N(4), .MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .sel(sel[1]), .in_valid(iv[1]),
    .in_data(id[1]), .in_ready(ir_b), .out_valid(ov_b), .out_data(od_b),
    .out_chan(oc_b), .out_ready(ordy[1]));

  stream_mux_rr #(.WIDTH(8), .N(3), .MODE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .sel(sel[2]), .in_valid(iv[2][2:0]),
    .in_data(id[2][23:0]), .in_ready(ir_c), .out_valid(ov_c), .out_data(od_c),
    .out_chan(oc_c), .out_ready(ordy[2]));

  stream_mux_rr #(.WIDTH(8), .N(3), .MODE(0)) u_d (
    .clk(clk), .rst_n(rst_n), .sel(sel[3]), .in_valid(iv[3][2:0]),
    .in_data(id[3][23:0]), .in_ready(ir_d), .out_valid(ov_d), .out_data(od_d),
    .out_chan(oc_d), .out_ready(ordy[3]));

  assign ir[0] = {2'b00, ir_a}; assign ov[0] = ov_a; assign od[0] = od_a; assign oc[0] = {1'b0, oc_a};
  assign ir[1] = ir_b;          assign ov[1] = ov_b; assign od[1] = od_b; assign oc[1] = oc_b;
  assign ir[2] = {1'b0, ir_c};  assign ov[2] = ov_c; assign od[2] = od_c; assign oc[2] = oc_c;
  assign ir[3] = {1'b0, ir_d};  assign ov[3] = ov_d; assign od[3] = od_d; assign oc[3] = oc_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected output words {chan[1:0], data[7:0]}, oldest first; front is the held word.
  logic [9:0] sbq[$];
  logic       m_ov  [4];
  int         m_ptr [4];

  function automatic int n_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 4 : 3);
  endfunction

  function automatic bit is_rr(input int k);
    return (k == 1) || (k == 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic reset_models();
    for (int k = 0; k < 4; k++) begin
      m_ov[k]  = 1'b0;
      m_ptr[k] = n_of(k) - 1;
    end
    sbq.delete();
  endtask

  // One clock cycle on instance k: inputs already driven, sample at the falling edge.
  task automatic step(input int k);
    int         n;
    int         g;
    int         idx;
    logic       gv;
    logic       space;
    logic [3:0] exp_ir;
    logic [9:0] e;
    @(negedge clk);
    n     = n_of(k);
    space = !m_ov[k] || ordy[k];
    gv    = 1'b0;
    g     = 0;
    if (!is_rr(k)) begin
      if (int'(sel[k]) < n) begin
        g  = int'(sel[k]);
        gv = iv[k][g];
      end
    end else begin
      for (int j = 1; j <= n; j++) begin
        idx = (m_ptr[k] + j) % n;
        if (!gv && iv[k][idx]) begin
          g  = idx;
          gv = 1'b1;
        end
      end
    end
    exp_ir = (space && gv) ? (4'b0001 << g) : 4'b0000;
    check("in_ready", 32'(ir[k]), 32'(exp_ir));
    check("out_valid", 32'(ov[k]), 32'(m_ov[k]));
    if (m_ov[k]) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sbq[0];
        check("out_data", 32'(od[k]), 32'(e[7:0]));
        check("out_chan", 32'(oc[k]), 32'(e[9:8]));
        if (ordy[k]) void'(sbq.pop_front());
      end
    end
    if (space && gv) begin
      sbq.push_back({2'(g), id[k][g*8 +: 8]});
      m_ov[k] = 1'b1;
      if (is_rr(k)) m_ptr[k] = g;
    end else if (m_ov[k] && ordy[k]) begin
      m_ov[k] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      sel[k] = '0; iv[k] = '0; id[k] = '0; ordy[k] = 1'b1;
    end
    reset_models();
    rst_n  = 1'b0;
    iv[0]  = 4'b0011;
    sel[0] = 2'd1;
    id[0]  = 32'h0000_B2A1;
    #2;
    check("rst_out_valid", 32'(ov[0]), 32'd0);
    check("rst_out_data",  32'(od[0]), 32'd0);
    check("rst_out_chan",  32'(oc[0]), 32'd0);
    check("rst_in_ready",  32'(ir[0]), 32'd0);
    iv[0] = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Instance A: external select, N=2.
    iv[0] = 4'b0011; sel[0] = 2'd1; id[0] = 32'h0000_B2A1; ordy[0] = 1'b1;
    step(0);
    iv[0] = 4'b0000;
    step(0);
    iv[0] = 4'b0001; sel[0] = 2'd0; id[0] = 32'h0000_0011;
    step(0);
    id[0] = 32'h0000_0022; ordy[0] = 1'b0;
    repeat (3) step(0);
    ordy[0] = 1'b1;
    step(0);
    iv[0] = 4'b0000;
    repeat (2) step(0);

    // Reset asserted between edges while a word is held.
    iv[0] = 4'b0001; id[0] = 32'h0000_0033; ordy[0] = 1'b0;
    step(0);
    iv[0] = 4'b0011;
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(ov[0]), 32'd0);
    check("midrst_out_data",  32'(od[0]), 32'd0);
    check("midrst_out_chan",  32'(oc[0]), 32'd0);
    check("midrst_in_ready",  32'(ir[0]), 32'd0);
    reset_models();
    @(posedge clk);
    #1;
    check("inrst_in_ready", 32'(ir[0]), 32'd0);
    iv[0] = 4'b0000; ordy[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Instance B: round-robin, N=4, all channels busy.
    id[1] = 32'h4342_4140; iv[1] = 4'b1111; ordy[1] = 1'b1;
    repeat (5) step(1);
    iv[1] = 4'b0000;
    repeat (2) step(1);

    // Instance C: round-robin, N=3, skip and wrap.
    id[2] = 32'h0062_6160; ordy[2] = 1'b1;
    iv[2] = 4'b0010; step(2);
    iv[2] = 4'b0001; step(2);
    iv[2] = 4'b0011; step(2);
    iv[2] = 4'b0000;
    repeat (2) step(2);

    // Instance D: external select, N=3, out-of-range select.
    id[3] = 32'h0072_7170; sel[3] = 2'd3; iv[3] = 4'b0111; ordy[3] = 1'b1;
    repeat (5) step(3);
    sel[3] = 2'd2;
    step(3);
    iv[3] = 4'b0000;
    repeat (2) step(3);

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
